// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: accepts WIDTH-bit words on a valid/ready
// handshake and shifts them out LSB-first, with optional idle gap cycles between words.
module serial_word_tx #(
  parameter int WIDTH      = 32,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy,
  output logic [15:0]      word_count
);

  localparam int            BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [7:0]    LAST_GAP = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic          HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             busy_q, busy_d;
  logic [15:0]      word_count_q, word_count_d;
  logic             load;

  // Ready depends only on state and counters so upstream never sees a loop through in_valid.
  assign in_ready = (state_q == IDLE) ||
                    ((state_q == SHIFT) && (bit_cnt_q == LAST_BIT) && !HAS_GAP) ||
                    ((state_q == GAP) && (gap_cnt_q == LAST_GAP));
  assign load     = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    x_d          = x_q;
    x_valid_d    = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    word_count_d = word_count_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          word_count_d = word_count_q + 16'd1;
          if (HAS_GAP) begin
            state_d   = GAP;
            gap_cnt_d = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          x_d       = shreg_q[1];
          x_valid_d = 1'b1;
          eof_d     = ((bit_cnt_q + BW'(1)) == LAST_BIT);
        end
      end
      GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshakes only happen at word boundaries, so a load overrides the idle/gap exit above.
    if (load) begin
      state_d   = SHIFT;
      shreg_d   = in_word;
      bit_cnt_d = '0;
      x_d       = in_word[0];
      x_valid_d = 1'b1;
      sof_d     = 1'b1;
      eof_d     = 1'b0;
    end else begin
      shreg_d = shreg_d;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= 8'd0;
      x_q          <= 1'b0;
      x_valid_q    <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      x_q          <= x_d;
      x_valid_q    <= x_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      busy_q       <= busy_d;
      word_count_q <= word_count_d;
    end
  end

  assign x          = x_q;
  assign x_valid    = x_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign busy       = busy_q;
  assign word_count = word_count_q;

endmodule
